mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-side requester (I) and the data-cache miss/writeback requester (D).
- Arbitrates by round-robin. Sequences each fixed-latency memory access with a cycle counter, then returns read data with a one-cycle done pulse.
- Provides a D-side lock so a dirty-line writeback and its following refill run back-to-back with no I access between them.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 5, cycles the memory port is held per access; legal range is ≥1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- i_req  in  1  I-side request; held high until i_done
- i_addr  in  ADDR_W  I-side address
- d_req  in  1  D-side request; held high until d_done
- d_we  in  1  D-side write (writeback) when 1, read (refill) when 0
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  D-side write data
- d_lock  in  1  sampled in RESP; when 1, the next grant is reserved for D
- i_gnt  out  1  I owns the port (BUSY/RESP)
- d_gnt  out  1  D owns the port (BUSY/RESP)
- i_done  out  1  one-cycle pulse: I access complete
- d_done  out  1  one-cycle pulse: D access complete
- rdata  out  DATA_W  read data; valid while a done pulse is high
- mem_en  out  1  memory port active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, counter=0.
  - Priority pointer = D, lock_pending=0.
  - All outputs 0, rdata=0.
  - Reset mid-access aborts the access immediately: no done pulse and no further mem_en.
- State IDLE:
  - mem_en=0, no grant.
  - If any eligible request is present, latch the winner plus its addr/we/wdata (I is always a read), set counter=1, and go to BUSY.
- Winner selection:
  - If lock_pending=1: only D is eligible. If d_req=0 that cycle, clear lock_pending and arbitrate normally in the same cycle.
  - If both requests are eligible: the priority pointer wins.
  - If only one is eligible: that one wins.
  - On every grant, the pointer moves to the non-winner and lock_pending is cleared.
- State BUSY:
  - mem_en=1; mem_addr, mem_we, mem_wdata come from the latched registers and stay stable for all MEM_LATENCY cycles.
  - counter increments each cycle.
  - When counter==MEM_LATENCY: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go to RESP, reset counter to 0.
- State RESP:
  - mem_en=0; the winner's done is pulsed for exactly this cycle.
  - If the winner is D and d_lock==1, set lock_pending.
  - Go to IDLE.
- Grants: the winner's gnt is high for the whole of BUSY and RESP; it is low in IDLE.
- Latency: request seen in IDLE at cycle t → BUSY in cycles t+1..t+MEM_LATENCY → done at t+MEM_LATENCY+1. The earliest next grant is at t+MEM_LATENCY+2.
- Requester rules:
  - Drop req in the cycle after done, otherwise the request is re-arbitrated as a new one.
  - Request inputs are ignored outside IDLE; changes during BUSY have no effect.
- Width rules: counter width is clog2(MEM_LATENCY+1). No wrap is possible, because counter is reset at MEM_LATENCY.
- Simultaneous events: i_req and d_req rising in the same IDLE cycle are resolved by the pointer; right after reset, D wins.

Test Plan:
- After reset, d_req=1, d_we=0, d_addr=0x40, memory returns 0xDEADBEEF → d_gnt high for 6 cycles, mem_en high for 5, d_done at request+6, rdata=0xDEADBEEF, i_done stays 0.
- i_req and d_req both held continuously, each dropped/re-raised after its own done → grant order D, I, D, I; each access 7 cycles apart.
- D write (d_we=1, addr 0x80, wdata 0x12345678) with d_lock=1 at RESP, i_req already high, then D read 0x80 → the read is granted before I. mem_we=1 only during the write's BUSY cycles; rdata is unchanged by the write.
- d_lock=1 at RESP but d_req=0 in the next IDLE cycle while i_req=1 → lock_pending clears and I is granted in that same cycle.
- reset driven low on the 3rd BUSY cycle of an I read → next cycle IDLE, all outputs 0, no i_done. A fresh i_req afterwards completes normally, with D-first pointer restored.
- MEM_LATENCY=1 build: single request → one BUSY cycle, done on the 2nd cycle after the request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port
// between the instruction fetch side and the data cache side.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              win_d;
    logic              ptr_d;
    logic              lock_pending;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              grant;
    logic              grant_d;
    logic              lock_clr;
    logic              busy;
    logic              resp;
    logic              own;

    // Next-state and winner selection; a reserved grant only
    // holds while D still requests, otherwise arbitrate normally.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        lock_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (lock_pending && !d_req) begin
                    lock_clr = 1'b1;
                end
                if (lock_pending && d_req) begin
                    grant   = 1'b1;
                    grant_d = 1'b1;
                end else if (d_req && i_req) begin
                    grant   = 1'b1;
                    grant_d = ptr_d;
                end else if (d_req) begin
                    grant   = 1'b1;
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant   = 1'b1;
                    grant_d = 1'b0;
                end
                if (grant) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus latched request, counter, pointer and lock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            win_d        <= 1'b0;
            ptr_d        <= 1'b1;
            lock_pending <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant) begin
                        win_d        <= grant_d;
                        ptr_d        <= !grant_d;
                        lock_pending <= 1'b0;
                        cnt          <= CW'(1);
                        addr_q       <= grant_d ? d_addr : i_addr;
                        we_q         <= grant_d & d_we;
                        wdata_q      <= grant_d ? d_wdata : '0;
                    end else if (lock_clr) begin
                        lock_pending <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (win_d && d_lock) begin
                        lock_pending <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Port and handshake outputs decoded from the registered state.
    always_comb begin
        busy      = (state == BUSY);
        resp      = (state == RESP);
        own       = busy | resp;
        i_gnt     = own & !win_d;
        d_gnt     = own & win_d;
        i_done    = resp & !win_d;
        d_done    = resp & win_d;
        rdata     = rdata_q;
        mem_en    = busy;
        mem_we    = busy & we_q;
        mem_addr  = busy ? addr_q : '0;
        mem_wdata = busy ? wdata_q : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin order, lock,
// write/read sequencing, mid-access reset and a latency-1 build.
module tb_mem_port_arbiter;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        i_gnt;
    logic        d_gnt;
    logic        i_done;
    logic        d_done;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        b_i_req;
    logic [31:0] b_i_addr;
    logic        b_d_req;
    logic        b_d_we;
    logic [31:0] b_d_addr;
    logic [31:0] b_d_wdata;
    logic        b_d_lock;
    logic        b_i_gnt;
    logic        b_d_gnt;
    logic        b_i_done;
    logic        b_d_done;
    logic [31:0] b_rdata;
    logic        b_mem_en;
    logic        b_mem_we;
    logic [31:0] b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] b_mem_rdata;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_lock   (d_lock),
        .i_gnt    (i_gnt),
        .d_gnt    (d_gnt),
        .i_done   (i_done),
        .d_done   (d_done),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LATENCY(1)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .i_req    (b_i_req),
        .i_addr   (b_i_addr),
        .d_req    (b_d_req),
        .d_we     (b_d_we),
        .d_addr   (b_d_addr),
        .d_wdata  (b_d_wdata),
        .d_lock   (b_d_lock),
        .i_gnt    (b_i_gnt),
        .d_gnt    (b_d_gnt),
        .i_done   (b_i_done),
        .d_done   (b_d_done),
        .rdata    (b_rdata),
        .mem_en   (b_mem_en),
        .mem_we   (b_mem_we),
        .mem_addr (b_mem_addr),
        .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_igE"}, i_gnt, 1'b0);
        chk({tag, "_dgE"}, d_gnt, 1'b0);
        chk({tag, "_enE"}, mem_en, 1'b0);
    endtask

    // Ticks the grant edge, then checks every BUSY cycle and RESP.
    task automatic expect_access(input string tag, input bit is_d,
                                 input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rd);
        tick();
        for (int k = 0; k < L; k++) begin
            chk({tag, "_gnt"}, is_d ? d_gnt : i_gnt, 1'b1);
            chk({tag, "_ogn"}, is_d ? i_gnt : d_gnt, 1'b0);
            chk({tag, "_en"}, mem_en, 1'b1);
            chk({tag, "_we"}, mem_we, we);
            chk({tag, "_addr"}, mem_addr, addr);
            if (we) chk({tag, "_wd"}, mem_wdata, wdata);
            chk({tag, "_idn"}, i_done, 1'b0);
            chk({tag, "_ddn"}, d_done, 1'b0);
            tick();
        end
        chk({tag, "_rgnt"}, is_d ? d_gnt : i_gnt, 1'b1);
        chk({tag, "_done"}, is_d ? d_done : i_done, 1'b1);
        chk({tag, "_odone"}, is_d ? i_done : d_done, 1'b0);
        chk({tag, "_ren"}, mem_en, 1'b0);
        chk({tag, "_rwe"}, mem_we, 1'b0);
        chk({tag, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_lock    = 1'b0;
        mem_rdata = '0;
        b_i_req   = 1'b0;
        b_i_addr  = '0;
        b_d_req   = 1'b0;
        b_d_we    = 1'b0;
        b_d_addr  = '0;
        b_d_wdata = '0;
        b_d_lock  = 1'b0;
        b_mem_rdata = '0;

        tick();
        tick();
        chk("rst_igt", i_gnt, 1'b0);
        chk("rst_dgt", d_gnt, 1'b0);
        chk("rst_idn", i_done, 1'b0);
        chk("rst_ddn", d_done, 1'b0);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rd", rdata, 32'h0);
        reset = 1'b1;

        d_req     = 1'b1;
        d_addr    = 32'h40;
        mem_rdata = 32'hDEADBEEF;
        expect_access("d40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();
        chk_idle("d40i");
        chk("d40i_dn", d_done, 1'b0);

        reset = 1'b0;
        tick();
        chk("rst2_rd", rdata, 32'h0);
        reset = 1'b1;

        d_addr    = 32'h100;
        i_addr    = 32'h200;
        i_req     = 1'b1;
        d_req     = 1'b1;
        mem_rdata = 32'hA0A00001;
        expect_access("rr1", 1'b1, 1'b0, 32'h100, 32'h0, 32'hA0A00001);
        d_req = 1'b0;
        tick();
        chk_idle("rr1i");
        d_req     = 1'b1;
        mem_rdata = 32'hB0B00002;
        expect_access("rr2", 1'b0, 1'b0, 32'h200, 32'h0, 32'hB0B00002);
        i_req = 1'b0;
        tick();
        chk_idle("rr2i");
        i_req     = 1'b1;
        mem_rdata = 32'hC0C00003;
        expect_access("rr3", 1'b1, 1'b0, 32'h100, 32'h0, 32'hC0C00003);
        d_req = 1'b0;
        tick();
        chk_idle("rr3i");
        d_req     = 1'b1;
        mem_rdata = 32'hD0D00004;
        expect_access("rr4", 1'b0, 1'b0, 32'h200, 32'h0, 32'hD0D00004);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk_idle("rr4i");

        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h80;
        d_wdata   = 32'h12345678;
        i_req     = 1'b1;
        i_addr    = 32'h240;
        mem_rdata = 32'h55555555;
        expect_access("wb", 1'b1, 1'b1, 32'h80, 32'h12345678, 32'hD0D00004);
        d_lock    = 1'b1;
        d_we      = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        tick();
        chk_idle("wbi");
        d_lock = 1'b0;
        expect_access("rf", 1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D);
        d_req = 1'b0;
        tick();
        chk_idle("rfi");
        mem_rdata = 32'h11111111;
        expect_access("ia", 1'b0, 1'b0, 32'h240, 32'h0, 32'h11111111);
        i_req = 1'b0;
        tick();

        d_req     = 1'b1;
        d_addr    = 32'h300;
        mem_rdata = 32'h22222222;
        expect_access("dl", 1'b1, 1'b0, 32'h300, 32'h0, 32'h22222222);
        d_lock = 1'b1;
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h400;
        tick();
        chk_idle("dli");
        d_lock    = 1'b0;
        mem_rdata = 32'h33333333;
        expect_access("lc", 1'b0, 1'b0, 32'h400, 32'h0, 32'h33333333);
        i_req = 1'b0;
        tick();

        i_req     = 1'b1;
        i_addr    = 32'h500;
        mem_rdata = 32'h44444444;
        tick();
        chk("ab_gnt", i_gnt, 1'b1);
        chk("ab_en", mem_en, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        i_req = 1'b0;
        tick();
        chk("ab_igt", i_gnt, 1'b0);
        chk("ab_dgt", d_gnt, 1'b0);
        chk("ab_idn", i_done, 1'b0);
        chk("ab_ddn", d_done, 1'b0);
        chk("ab_en0", mem_en, 1'b0);
        chk("ab_we0", mem_we, 1'b0);
        chk("ab_addr", mem_addr, 32'h0);
        chk("ab_wd", mem_wdata, 32'h0);
        chk("ab_rd", rdata, 32'h0);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ab_nodn", i_done, 1'b0);
            chk("ab_noen", mem_en, 1'b0);
        end
        i_req     = 1'b1;
        d_req     = 1'b1;
        d_addr    = 32'h600;
        mem_rdata = 32'h66666666;
        expect_access("pd", 1'b1, 1'b0, 32'h600, 32'h0, 32'h66666666);
        d_req = 1'b0;
        tick();
        chk_idle("pdi");
        mem_rdata = 32'h77777777;
        expect_access("pi", 1'b0, 1'b0, 32'h500, 32'h0, 32'h77777777);
        i_req = 1'b0;
        tick();
        chk_idle("pii");

        b_i_req     = 1'b1;
        b_i_addr    = 32'h900;
        b_mem_rdata = 32'h9ABCDEF0;
        tick();
        chk("l1_en", b_mem_en, 1'b1);
        chk("l1_gnt", b_i_gnt, 1'b1);
        chk("l1_addr", b_mem_addr, 32'h900);
        chk("l1_dn0", b_i_done, 1'b0);
        tick();
        chk("l1_dn", b_i_done, 1'b1);
        chk("l1_en1", b_mem_en, 1'b0);
        chk("l1_rd", b_rdata, 32'h9ABCDEF0);
        chk("l1_dd", b_d_done, 1'b0);
        b_i_req = 1'b0;
        tick();
        chk("l1_dn2", b_i_done, 1'b0);
        chk("l1_gnt2", b_i_gnt, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
